// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integer baud divider, a compile-time
// frame format (5..9 data bits, none/even/odd parity, 1 or 2 stop bits) and a
// small transmit FIFO behind a valid/ready push port. Queued words are sent
// back-to-back, with the next start bit directly after the last stop bit.

module uart_tx_fifo #(
   parameter int CLK_FREQ   = 12000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int IDX_W = $clog2(DATA_BITS);

   // Reject frame formats and FIFO sizes the datapath cannot represent.
   generate
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
         $error("uart_tx_fifo: DATA_BITS must be in 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
         $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
         $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
      end
      if (DIV < 1) begin : g_bad_div
         $error("uart_tx_fifo: BAUD too high for CLK_FREQ");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [LVL_W-1:0]       level;
   logic [DATA_BITS-1:0]   head;
   logic [DATA_BITS-1:0]   shift;
   logic [DATA_BITS-1:0]   shift_next;
   logic [IDX_W-1:0]       bit_idx;
   logic [IDX_W-1:0]       bit_idx_next;
   logic                   par_bit;
   logic                   par_next;
   logic                   stop_cnt;
   logic                   stop_next;
   logic [CNT_W-1:0]       baud_cnt;
   logic                   tick;
   logic                   push;
   logic                   pop;
   logic                   fifo_nonempty;
   logic                   head_parity;
   logic                   tx_next;

   assign tx_ready      = !rst && (level != LVL_W'(FIFO_DEPTH));
   assign push          = tx_valid && tx_ready;
   assign fifo_nonempty = (level != '0);
   assign head          = mem[rd_ptr];
   assign head_parity   = (PARITY == 2) ? ~(^head) : (^head);
   assign tick          = (baud_cnt == CNT_W'(DIV - 1));
   assign fifo_level    = level;
   assign tx_busy       = (state != S_IDLE) || fifo_nonempty;

   // FIFO storage; a flush only needs the pointers reset, not the contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave the level alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            level <= level + LVL_W'(1);
         end else if (pop && !push) begin
            level <= level - LVL_W'(1);
         end
      end
   end

   // Baud counter restarts with every frame so each bit lasts exactly DIV cycles.
   always_ff @(posedge clk) begin
      if (rst || pop || state == S_IDLE || tick) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + CNT_W'(1);
      end
   end

   // Frame sequencer state, shifter and the registered serial output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         shift    <= '0;
         bit_idx  <= '0;
         par_bit  <= 1'b0;
         stop_cnt <= 1'b0;
         tx       <= 1'b1;
      end else begin
         state    <= state_next;
         shift    <= shift_next;
         bit_idx  <= bit_idx_next;
         par_bit  <= par_next;
         stop_cnt <= stop_next;
         tx       <= tx_next;
      end
   end

   // Next-state logic; popping from STOP chains the next frame without a gap.
   always_comb begin
      state_next   = state;
      shift_next   = shift;
      bit_idx_next = bit_idx;
      par_next     = par_bit;
      stop_next    = stop_cnt;
      pop          = 1'b0;
      case (state)
         S_IDLE: begin
            if (fifo_nonempty) begin
               pop        = 1'b1;
               shift_next = head;
               par_next   = head_parity;
               state_next = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               bit_idx_next = '0;
               state_next   = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_next = shift >> 1;
               if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                  stop_next  = 1'b0;
                  state_next = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_next = bit_idx + IDX_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               stop_next  = 1'b0;
               state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (stop_cnt == 1'(STOP_BITS - 1)) begin
                  if (fifo_nonempty) begin
                     pop        = 1'b1;
                     shift_next = head;
                     par_next   = head_parity;
                     state_next = S_START;
                  end else begin
                     state_next = S_IDLE;
                  end
               end else begin
                  stop_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Line level for the upcoming cycle, derived from the state being entered.
   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         S_START:  tx_next = 1'b0;
         S_DATA:   tx_next = shift_next[0];
         S_PARITY: tx_next = par_next;
         default:  tx_next = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at DIV=4 with four frame
// formats (8N1, 7E2, 8O1, 9E1). Expected line waveforms are rebuilt bit by
// bit from the pushed word and the format, then compared every clock.

module tb_uart_tx_fifo;

   localparam int DIV = 4;

   logic       clk;
   logic       rst;
   logic [8:0] data;
   logic [3:0] valid;
   logic [3:0] ready;
   logic [3:0] line;
   logic [3:0] busy;
   logic [2:0] level [4];

   int   sel;
   logic tx_sel;
   logic busy_sel;
   logic ready_sel;
   logic [2:0] level_sel;

   int check_count;
   int pass_count;

   int cfg_bits [4] = '{8, 7, 8, 9};
   int cfg_par  [4] = '{0, 1, 2, 1};
   int cfg_stop [4] = '{1, 2, 1, 1};

   logic [8:0] stream_words [$];

   uart_tx_fifo #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
      .clk(clk), .rst(rst), .tx_data(data[7:0]), .tx_valid(valid[0]),
      .tx_ready(ready[0]), .tx(line[0]), .tx_busy(busy[0]), .fifo_level(level[0]));

   uart_tx_fifo #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
      .clk(clk), .rst(rst), .tx_data(data[6:0]), .tx_valid(valid[1]),
      .tx_ready(ready[1]), .tx(line[1]), .tx_busy(busy[1]), .fifo_level(level[1]));

   uart_tx_fifo #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
      .clk(clk), .rst(rst), .tx_data(data[7:0]), .tx_valid(valid[2]),
      .tx_ready(ready[2]), .tx(line[2]), .tx_busy(busy[2]), .fifo_level(level[2]));

   uart_tx_fifo #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(9), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_9e1 (
      .clk(clk), .rst(rst), .tx_data(data), .tx_valid(valid[3]),
      .tx_ready(ready[3]), .tx(line[3]), .tx_busy(busy[3]), .fifo_level(level[3]));

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Route the instance under test onto common observation signals.
   always_comb begin
      tx_sel    = line[sel];
      busy_sel  = busy[sel];
      ready_sel = ready[sel];
      level_sel = level[sel];
   end

   // Hard stop in case a bounded wait is ever bypassed.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] simulation timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Push one word into instance s; called on a falling edge, returns one edge later.
   task automatic applyStimulus(input int s, input logic [8:0] word);
      data     = word;
      valid[s] = 1'b1;
      @(negedge clk);
      valid[s] = 1'b0;
   endtask

   // Wait for a start bit and check how many falling edges it took.
   task automatic waitStart(input string tag, input int expected_latency);
      int n;
      n = 0;
      while (tx_sel !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, " latency"}, n, expected_latency);
   endtask

   // Check a whole frame cycle by cycle, starting on the first start-bit sample.
   task automatic checkFrame(input string tag, input logic [8:0] word);
      logic bits [$];
      int   ones;
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < cfg_bits[sel]; i++) begin
         bits.push_back(word[i]);
         ones += int'(word[i]);
      end
      if (cfg_par[sel] == 1) begin
         bits.push_back((ones % 2) == 1);
      end else if (cfg_par[sel] == 2) begin
         bits.push_back((ones % 2) == 0);
      end
      for (int i = 0; i < cfg_stop[sel]; i++) begin
         bits.push_back(1'b1);
      end
      for (int b = 0; b < bits.size(); b++) begin
         for (int k = 0; k < DIV; k++) begin
            checkOutput($sformatf("%s bit%0d cyc%0d", tag, b, k), tx_sel, bits[b]);
            if (b == bits.size() - 1 && k == DIV - 1) begin
               checkOutput({tag, " busy in last stop"}, busy_sel, 1);
            end
            @(negedge clk);
         end
      end
   endtask

   // Line idle and FIFO drained.
   task automatic checkIdle(input string tag);
      checkOutput({tag, " idle tx"}, tx_sel, 1);
      checkOutput({tag, " idle busy"}, busy_sel, 0);
      checkOutput({tag, " idle level"}, level_sel, 0);
   endtask

   // Directed test sequence.
   initial begin
      check_count = 0;
      pass_count  = 0;
      sel   = 0;
      rst   = 1'b1;
      valid = '0;
      data  = '0;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rst tx", tx_sel, 1);
      checkOutput("rst busy", busy_sel, 0);
      checkOutput("rst level", level_sel, 0);
      checkOutput("rst ready low", ready_sel, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post rst ready", ready_sel, 1);

      // 8N1 single word, latency and busy timing
      applyStimulus(0, 9'h0A5);
      checkOutput("8n1 level after push", level_sel, 1);
      checkOutput("8n1 tx before pop", tx_sel, 1);
      checkOutput("8n1 busy", busy_sel, 1);
      waitStart("8n1", 1);
      checkFrame("8n1 a5", 9'h0A5);
      checkIdle("8n1");

      // 7E2
      sel = 1;
      applyStimulus(1, 9'h035);
      waitStart("7e2", 1);
      checkFrame("7e2 35", 9'h035);
      checkIdle("7e2");

      // 8O1
      sel = 2;
      applyStimulus(2, 9'h000);
      waitStart("8o1 00", 1);
      checkFrame("8o1 00", 9'h000);
      checkIdle("8o1 00");
      applyStimulus(2, 9'h07F);
      waitStart("8o1 7f", 1);
      checkFrame("8o1 7f", 9'h07F);
      checkIdle("8o1 7f");

      // 9E1
      sel = 3;
      applyStimulus(3, 9'h1AB);
      waitStart("9e1", 1);
      checkFrame("9e1 1ab", 9'h1AB);
      checkIdle("9e1");

      // Held valid stream of six words through a depth-4 FIFO
      sel = 0;
      stream_words = '{9'h01, 9'h02, 9'h03, 9'h04, 9'h05, 9'h06};
      fork
         begin
            int  idx;
            int  guard;
            logic accept;
            idx   = 0;
            guard = 0;
            while (idx < stream_words.size() && guard < 1000) begin
               data     = stream_words[idx];
               valid[0] = 1'b1;
               accept   = ready_sel;
               @(negedge clk);
               if (accept) idx++;
               guard++;
            end
            valid[0] = 1'b0;
         end
         begin
            int guard;
            guard = 0;
            while (tx_sel !== 1'b0 && guard < 50) begin
               @(negedge clk);
               guard++;
            end
            checkOutput("stream level 1", level_sel, 1);
            @(negedge clk);
            checkOutput("stream level 2", level_sel, 2);
            @(negedge clk);
            checkOutput("stream level 3", level_sel, 3);
            @(negedge clk);
            checkOutput("stream level 4", level_sel, 4);
            checkOutput("stream ready full", ready_sel, 0);
         end
         begin
            waitStart("stream", 2);
            foreach (stream_words[i]) begin
               checkFrame($sformatf("stream w%0d", i), stream_words[i]);
            end
            checkIdle("stream");
         end
      join

      // Full FIFO: a push offered on the pop edge is dropped because ready is low
      fork
         begin
            data = 9'h010; valid[0] = 1'b1;
            @(negedge clk); data = 9'h011;
            @(negedge clk); data = 9'h012;
            @(negedge clk); data = 9'h013;
            @(negedge clk); data = 9'h014;
            @(negedge clk); valid[0] = 1'b0;
            repeat (36) @(negedge clk);
            checkOutput("full level", level_sel, 4);
            checkOutput("full ready", ready_sel, 0);
            data = 9'h0EE; valid[0] = 1'b1;
            @(negedge clk);
            valid[0] = 1'b0;
            checkOutput("after pop level", level_sel, 3);
            checkOutput("after pop ready", ready_sel, 1);
         end
         begin
            waitStart("full", 2);
            checkFrame("full w10", 9'h010);
            checkFrame("full w11", 9'h011);
            checkFrame("full w12", 9'h012);
            checkFrame("full w13", 9'h013);
            checkFrame("full w14", 9'h014);
            checkIdle("full");
         end
      join

      // Reset during data bit 3 aborts the frame and flushes the queue
      applyStimulus(0, 9'h052);
      applyStimulus(0, 9'h03C);
      repeat (17) @(negedge clk);
      checkOutput("abort bit3 tx", tx_sel, 0);
      checkOutput("abort level", level_sel, 1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort tx", tx_sel, 1);
      checkOutput("abort busy", busy_sel, 0);
      checkOutput("abort level flushed", level_sel, 0);
      checkOutput("abort ready in rst", ready_sel, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort ready after", ready_sel, 1);
      begin
         int lows;
         lows = 0;
         repeat (80) begin
            if (tx_sel !== 1'b1) lows++;
            @(negedge clk);
         end
         checkOutput("abort no frame", lows, 0);
      end
      checkIdle("abort");

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
